// File: rtl/ysyx_23060203_mem_arb_rr.sv
// rtl/ysyx_23060203_mem_arb_rr.sv - N-master AXI4 read arbiter, fixed or round-robin, one burst in flight
module ysyx_23060203_mem_arb_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        s_arvalid,
  output logic [NUM_MASTERS-1:0]        s_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MASTERS*8-1:0]      s_arlen,
  input  logic [NUM_MASTERS*3-1:0]      s_arsize,
  output logic [NUM_MASTERS-1:0]        s_rvalid,
  input  logic [NUM_MASTERS-1:0]        s_rready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [3:0]                    m_arid,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state, state_nx;
  logic [IDX_W-1:0]       grant_nx, rr_ptr, rr_ptr_nx, win_idx;
  logic                   win_found;
  logic [NUM_MASTERS-1:0] grant_oh, req_sh;
  int                     cand;

  // Search starts at rr_ptr in round-robin mode, at 0 in fixed mode; first requester wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    req_sh    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (RR_MODE != 0) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      end else begin
        cand = k;
      end
      req_sh = s_arvalid >> cand;
      if (!win_found && req_sh[0]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_oh = NUM_MASTERS'(1) << grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    rr_ptr_nx = rr_ptr;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nx = win_idx;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        // A granted master that withdraws arvalid simply holds the port in ADDR.
        m_arvalid = |(s_arvalid & grant_oh);
        s_arready = grant_oh & {NUM_MASTERS{m_arready}};
        if (m_arvalid && m_arready) state_nx = DATA;
      end
      DATA: begin
        s_rvalid = grant_oh & {NUM_MASTERS{m_rvalid}};
        m_rready = |(s_rready & grant_oh);
        if (m_rvalid && m_rready && m_rlast) begin
          state_nx = IDLE;
          if (RR_MODE != 0)
            rr_ptr_nx = (grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign m_araddr = ADDR_W'(s_araddr >> (grant * ADDR_W));
  assign m_arlen  = 8'(s_arlen >> (grant * 8));
  assign m_arsize = 3'(s_arsize >> (grant * 3));
  assign m_arid   = 4'(grant);
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ysyx_23060203_mem_arb_rr.sv
// tb/tb_ysyx_23060203_mem_arb_rr.sv - scoreboard bench: 4-master round-robin and 3-master fixed arbiters
`timescale 1ns/1ps
module tb_ysyx_23060203_mem_arb_rr;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*32-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [31:0]     s_rdata, m_araddr, m_rdata;
  logic [1:0]      s_rresp, m_rresp, grant;
  logic            s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, busy;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [3:0]      m_arid;

  logic [2:0]  fx_s_arvalid, fx_s_arready, fx_s_rvalid, fx_s_rready;
  logic [95:0] fx_s_araddr;
  logic [23:0] fx_s_arlen;
  logic [8:0]  fx_s_arsize;
  logic [31:0] fx_s_rdata, fx_m_araddr, fx_m_rdata;
  logic [1:0]  fx_s_rresp, fx_m_rresp, fx_grant;
  logic        fx_s_rlast, fx_m_arvalid, fx_m_arready, fx_m_rvalid, fx_m_rready, fx_m_rlast, fx_busy;
  logic [7:0]  fx_m_arlen;
  logic [2:0]  fx_m_arsize;
  logic [3:0]  fx_m_arid;

  ysyx_23060203_mem_arb_rr #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_rr (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .busy(busy), .grant(grant)
  );

  ysyx_23060203_mem_arb_rr #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_fx (
    .clock(clock), .reset(reset),
    .s_arvalid(fx_s_arvalid), .s_arready(fx_s_arready), .s_araddr(fx_s_araddr), .s_arlen(fx_s_arlen),
    .s_arsize(fx_s_arsize), .s_rvalid(fx_s_rvalid), .s_rready(fx_s_rready), .s_rdata(fx_s_rdata),
    .s_rresp(fx_s_rresp), .s_rlast(fx_s_rlast),
    .m_arvalid(fx_m_arvalid), .m_arready(fx_m_arready), .m_araddr(fx_m_araddr), .m_arlen(fx_m_arlen),
    .m_arsize(fx_m_arsize), .m_arid(fx_m_arid), .m_rvalid(fx_m_rvalid), .m_rready(fx_m_rready),
    .m_rdata(fx_m_rdata), .m_rresp(fx_m_rresp), .m_rlast(fx_m_rlast), .busy(fx_busy), .grant(fx_grant)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [1:0] m; logic [31:0] data; logic [1:0] resp; logic last;} r_t;

  ar_t        exp_ar[$];
  r_t         exp_r[$];
  logic [3:0] exp_fx[$];
  int total = 0;
  int bad   = 0;
  int r_cnt = 0;
  int fx_cnt = 0;
  logic [1:0] slv_resp;

  logic [31:0] rq_addr [N][16];
  logic [7:0]  rq_len  [N][16];
  int mhead [N];
  int mtail [N];

  function automatic logic [31:0] dgen(input logic [31:0] a);
    return a ^ 32'h5EAD_BEFF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_req(input int m, input logic [31:0] a, input int len);
    rq_addr[m][mtail[m] % 16] = a;
    rq_len[m][mtail[m] % 16]  = 8'(len);
    mtail[m]++;
  endtask

  task automatic expect_txn(input int m, input logic [31:0] a, input int len,
                            input logic [1:0] resp, input logic [31:0] d0);
    ar_t ea;
    r_t  er;
    ea.id = 4'(m); ea.addr = a; ea.len = 8'(len);
    exp_ar.push_back(ea);
    for (int b = 0; b <= len; b++) begin
      er.m = 2'(m); er.data = d0 + 32'(b); er.resp = resp; er.last = (b == len);
      exp_r.push_back(er);
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((exp_ar.size() != 0 || exp_r.size() != 0 || busy) && n < budget);
    chk(nm, 64'(exp_ar.size() == 0 && exp_r.size() == 0 && !busy), 64'd1);
  endtask

  // Upstream masters: each one presents the head of its request list until accepted.
  initial begin : masters
    logic [N-1:0] hs;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    for (int i = 0; i < N; i++) begin mhead[i] = 0; mtail[i] = 0; end
    forever begin
      @(negedge clock);
      hs = s_arvalid & s_arready & {N{!reset}};
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) mhead[i]++;
        s_arvalid[i]          = (mhead[i] != mtail[i]);
        s_araddr[i*32 +: 32]  = rq_addr[i][mhead[i] % 16];
        s_arlen[i*8 +: 8]     = rq_len[i][mhead[i] % 16];
        s_arsize[i*3 +: 3]    = 3'd2;
      end
    end
  end

  // Downstream slave: after an AR it returns arlen+1 beats, data derived from the address.
  initial begin : slave
    logic ar_hs, r_hs, rst_s, active;
    logic [31:0] cur;
    logic [7:0]  clen;
    int beat;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    active = 1'b0; beat = 0; cur = '0; clen = '0;
    forever begin
      @(negedge clock);
      rst_s = reset;
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      if (ar_hs) begin cur = m_araddr; clen = m_arlen; end
      @(posedge clock);
      #1;
      if (rst_s) active = 1'b0;
      else begin
        if (r_hs) begin
          if (m_rlast) active = 1'b0;
          else beat++;
        end
        if (ar_hs) begin active = 1'b1; beat = 0; end
      end
      m_rvalid = active;
      m_rdata  = dgen(cur) + 32'(beat);
      m_rlast  = (beat == int'(clen));
      m_rresp  = slv_resp;
    end
  end

  always @(negedge clock) begin : monitor_rr
    ar_t ea;
    r_t  er;
    if (!reset) begin
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(m_arid), 64'hF);
        else begin
          ea = exp_ar.pop_front();
          chk("ar_id", 64'(m_arid), 64'(ea.id));
          chk("ar_addr_len_size", {m_araddr, m_arlen, m_arsize}, {ea.addr, ea.len, 3'd2});
        end
      end
      if (s_rvalid != '0) begin
        chk("rvalid_onehot", 64'($countones(s_rvalid)), 64'd1);
        for (int i = 0; i < N; i++) begin
          if (s_rvalid[i] && s_rready[i]) begin
            r_cnt++;
            if (exp_r.size() == 0) chk("r_unexpected", 64'(i), 64'hF);
            else begin
              er = exp_r.pop_front();
              chk("r_master", 64'(i), 64'(er.m));
              chk("r_data_resp_last", {s_rdata, s_rresp, s_rlast}, {er.data, er.resp, er.last});
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin : monitor_fx
    logic [3:0] e;
    if (!reset) begin
      if (fx_m_arvalid && fx_m_arready) begin
        fx_cnt++;
        if (exp_fx.size() == 0) chk("fx_unexpected", 64'(fx_m_arid), 64'hF);
        else begin
          e = exp_fx.pop_front();
          chk("fx_arid", 64'(fx_m_arid), 64'(e));
          chk("fx_grant", 64'(fx_grant), 64'(e));
          chk("fx_s_arready", 64'(fx_s_arready), 64'(3'b001 << e));
          chk("fx_ar_fields", {fx_m_araddr, fx_m_arlen, fx_m_arsize, fx_m_rready},
              {32'hA000_0000 + 32'(e) * 32'd16, 8'd0, 3'd2, 1'b0});
        end
      end
      if (fx_s_rvalid != '0)
        chk("fx_r_pass", {fx_s_rdata, fx_s_rresp, fx_s_rlast}, {32'hC0FF_EE00, 2'b00, 1'b1});
    end
  end

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int r0;
    reset = 1'b1; s_rready = '1; slv_resp = 2'b00;
    fx_s_arvalid = '0; fx_s_rready = '1;
    fx_s_araddr = {32'hA000_0020, 32'hA000_0010, 32'hA000_0000};
    fx_s_arlen = '0; fx_s_arsize = {3'd2, 3'd2, 3'd2};
    fx_m_arready = 1'b1; fx_m_rvalid = 1'b1; fx_m_rdata = 32'hC0FF_EE00;
    fx_m_rresp = 2'b00; fx_m_rlast = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ready_valid", {s_arready, s_rvalid, m_arvalid, m_rready}, '0);
    chk("rst_fx_busy", 64'(fx_busy), 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // Single request from master 1.
    expect_txn(1, 32'h8000_0010, 0, 2'b00, 32'hDEAD_BEEF);
    push_req(1, 32'h8000_0010, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!s_arvalid[1] && n < 20);
    chk("t1_arvalid_seen", 64'(s_arvalid[1]), 64'd1);
    chk("t1_idle_before", 64'(busy), 64'd0);
    @(negedge clock);
    chk("t1_grant", 64'(grant), 64'd1);
    chk("t1_m_arvalid", 64'(m_arvalid), 64'd1);
    wait_drain("t1_drain", 30);

    // Reset during a 4-beat burst from master 2.
    expect_txn(2, 32'h8000_2000, 3, 2'b00, dgen(32'h8000_2000));
    push_req(2, 32'h8000_2000, 3);
    r0 = r_cnt; n = 0;
    do begin @(negedge clock); #1; n++; end while (r_cnt < r0 + 2 && n < 40);
    chk("rst_mid_two_beats", 64'(r_cnt), 64'(r0 + 2));
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_grant", 64'(grant), 64'd0);
    chk("rst_mid_rvalid", {s_rvalid, m_rready}, '0);
    exp_r.delete();
    @(posedge clock); #1 reset = 1'b0;

    // Round-robin fairness: all four masters keep two single-beat requests pending.
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < N; m++) begin
        expect_txn(m, 32'h1000_0000 + 32'(m * 256 + k * 16), 0, 2'b00,
                   dgen(32'h1000_0000 + 32'(m * 256 + k * 16)));
        push_req(m, 32'h1000_0000 + 32'(m * 256 + k * 16), 0);
      end
    wait_drain("rr_drain", 200);

    // Burst hold: master 1 requests while master 0's 4-beat burst is in progress.
    expect_txn(0, 32'h2000_0000, 3, 2'b00, dgen(32'h2000_0000));
    push_req(0, 32'h2000_0000, 3);
    r0 = r_cnt; n = 0;
    do begin @(negedge clock); #1; n++; end while (r_cnt == r0 && n < 40);
    chk("bh_in_burst", 64'(r_cnt > r0), 64'd1);
    expect_txn(1, 32'h2000_1000, 0, 2'b00, dgen(32'h2000_1000));
    push_req(1, 32'h2000_1000, 0);
    wait_drain("bh_drain", 60);

    // Backpressure with SLVERR on master 3.
    slv_resp = 2'b10;
    s_rready[3] = 1'b0;
    expect_txn(3, 32'h3000_0000, 0, 2'b10, dgen(32'h3000_0000));
    push_req(3, 32'h3000_0000, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!s_rvalid[3] && n < 40);
    chk("bp_rvalid_seen", 64'(s_rvalid[3]), 64'd1);
    r0 = r_cnt;
    chk("bp_m_rready", 64'(m_rready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("bp_m_rready", 64'(m_rready), 64'd0);
    end
    chk("bp_no_beat", 64'(r_cnt), 64'(r0));
    @(posedge clock); #1 s_rready[3] = 1'b1;
    wait_drain("bp_drain", 30);
    slv_resp = 2'b00;

    // Fixed priority: masters 0 and 2 request together; 2 waits until 0 withdraws.
    for (int k = 0; k < 3; k++) exp_fx.push_back(4'd0);
    @(posedge clock); #1 fx_s_arvalid = 3'b101;
    n = 0;
    while (fx_cnt < 3 && n < 100) begin @(posedge clock); #1; n++; end
    chk("fx_three_to_m0", 64'(fx_cnt), 64'd3);
    fx_s_arvalid = 3'b100;
    exp_fx.push_back(4'd2);
    exp_fx.push_back(4'd2);
    n = 0;
    while (fx_cnt < 5 && n < 100) begin @(posedge clock); #1; n++; end
    chk("fx_two_to_m2", 64'(fx_cnt), 64'd5);
    fx_s_arvalid = 3'b000;
    repeat (4) @(negedge clock);
    chk("fx_idle_end", 64'(fx_busy), 64'd0);
    chk("fx_queue_empty", 64'(exp_fx.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
